ex_stage: RTL and testbench

- RV32I execute stage; sits directly upstream of the `alu` block and consumes what it produces.
- Decodes opcode/funct fields into `alu_op`, selects ALU operands and reads back `alu_out` and the flags.
- Resolves branches and jumps, raising a redirect.
- Registers results into the EX/MEM pipeline register behind a valid/ready handshake.

---
 rtl/ex_pkg.sv | 73 +++++++
 rtl/ex_decode.sv | 87 ++++++++
 rtl/ex_stage.sv | 158 +++++++++++++++
 tb/tb_ex_stage.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared types and constants for the RV32I execute stage.
// ALU op encoding, opcode/funct3 constants and the EX/MEM bundle.
package ex_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLL = 3'b101,
      ALU_SRL = 3'b110,
      ALU_SRA = 3'b111
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [1:0] ASEL_RS1  = 2'd0;
   localparam logic [1:0] ASEL_PC   = 2'd1;
   localparam logic [1:0] ASEL_ZERO = 2'd2;

   localparam logic BSEL_RS2 = 1'b0;
   localparam logic BSEL_IMM = 1'b1;

   localparam logic [1:0] RSEL_ALU = 2'd0;
   localparam logic [1:0] RSEL_LT  = 2'd1;
   localparam logic [1:0] RSEL_LTU = 2'd2;
   localparam logic [1:0] RSEL_PC4 = 2'd3;

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] store_data;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
   } ex_mem_t;

   // SLT/SLTU run a SUB; only the flags matter for them
   function automatic alu_op_e arith_op(
      input logic [2:0] f3,
      input logic       is_op,
      input logic       b5
   );
      case (f3)
         3'b000:  return (is_op && b5) ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SUB;
         3'b011:  return ALU_SUB;
         3'b100:  return ALU_XOR;
         3'b101:  return b5 ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/ex_decode.sv
// Combinational opcode/funct decode for the execute stage.
// Produces ALU op, operand selects and memory/writeback controls.
module ex_decode
   import ex_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_b5,
   output logic [2:0] alu_op,
   output logic [1:0] a_sel,
   output logic       b_sel,
   output logic [1:0] res_sel,
   output logic       reg_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       is_branch,
   output logic       is_jal,
   output logic       is_jalr
);

   logic [1:0] slt_sel;

   assign slt_sel = (funct3 == 3'b010) ? RSEL_LT :
                    (funct3 == 3'b011) ? RSEL_LTU : RSEL_ALU;

   always_comb begin
      alu_op    = ALU_ADD;
      a_sel     = ASEL_RS1;
      b_sel     = BSEL_RS2;
      res_sel   = RSEL_ALU;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      is_branch = 1'b0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
      unique case (1'b1)
         (opcode == OPC_OP): begin
            alu_op    = arith_op(funct3, 1'b1, funct7_b5);
            res_sel   = slt_sel;
            reg_write = 1'b1;
         end
         (opcode == OPC_OP_IMM): begin
            alu_op    = arith_op(funct3, 1'b0, funct7_b5);
            b_sel     = BSEL_IMM;
            res_sel   = slt_sel;
            reg_write = 1'b1;
         end
         (opcode == OPC_LUI): begin
            a_sel     = ASEL_ZERO;
            b_sel     = BSEL_IMM;
            reg_write = 1'b1;
         end
         (opcode == OPC_AUIPC): begin
            a_sel     = ASEL_PC;
            b_sel     = BSEL_IMM;
            reg_write = 1'b1;
         end
         (opcode == OPC_LOAD): begin
            b_sel     = BSEL_IMM;
            mem_read  = 1'b1;
            reg_write = 1'b1;
         end
         (opcode == OPC_STORE): begin
            b_sel     = BSEL_IMM;
            mem_write = 1'b1;
         end
         (opcode == OPC_BRANCH): begin
            alu_op    = ALU_SUB;
            is_branch = 1'b1;
         end
         (opcode == OPC_JAL): begin
            res_sel   = RSEL_PC4;
            reg_write = 1'b1;
            is_jal    = 1'b1;
         end
         (opcode == OPC_JALR): begin
            b_sel     = BSEL_IMM;
            res_sel   = RSEL_PC4;
            reg_write = 1'b1;
            is_jalr   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand select, branch resolution, redirect
// and the EX/MEM register behind a valid/ready handshake.
module ex_stage
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   output logic            id_ready,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [6:0]      id_opcode,
   input  logic [2:0]      id_funct3,
   input  logic            id_funct7_b5,
   input  logic [4:0]      id_rd,
   output logic [XLEN-1:0] alu_in1,
   output logic [XLEN-1:0] alu_in2,
   output logic [2:0]      alu_op,
   input  logic [XLEN-1:0] alu_out,
   input  logic            alu_zero,
   input  logic            alu_lt,
   input  logic            alu_ltu,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_result,
   output logic [XLEN-1:0] ex_store_data,
   output logic [4:0]      ex_rd,
   output logic [2:0]      ex_funct3,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_reg_write,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   input  logic            flush
);

   logic [1:0]      a_sel;
   logic [1:0]      res_sel;
   logic            b_sel;
   logic            d_rw;
   logic            d_mr;
   logic            d_mw;
   logic            is_br;
   logic            is_jal;
   logic            is_jalr;
   logic            cond;
   logic            take;
   logic            accept;
   logic [XLEN-1:0] pc4;
   logic [XLEN-1:0] br_tgt;
   logic [XLEN-1:0] tgt;
   ex_mem_t         d;
   ex_mem_t         q;
   logic            valid_q;
   logic            redir_q;
   logic [XLEN-1:0] rpc_q;

   ex_decode u_dec (
      .opcode    (id_opcode),
      .funct3    (id_funct3),
      .funct7_b5 (id_funct7_b5),
      .alu_op    (alu_op),
      .a_sel     (a_sel),
      .b_sel     (b_sel),
      .res_sel   (res_sel),
      .reg_write (d_rw),
      .mem_read  (d_mr),
      .mem_write (d_mw),
      .is_branch (is_br),
      .is_jal    (is_jal),
      .is_jalr   (is_jalr)
   );

   always_comb begin
      unique case (a_sel)
         ASEL_PC:   alu_in1 = id_pc;
         ASEL_ZERO: alu_in1 = '0;
         default:   alu_in1 = id_rs1_data;
      endcase
   end

   assign alu_in2 = (b_sel == BSEL_IMM) ? id_imm : id_rs2_data;

   // the ALU is busy with the compare, so targets use local adders
   assign pc4    = id_pc + 32'd4;
   assign br_tgt = id_pc + id_imm;
   assign tgt    = is_jalr ? (alu_out & ~32'd1) : br_tgt;

   always_comb begin
      case (id_funct3)
         F3_BEQ:  cond = alu_zero;
         F3_BNE:  cond = !alu_zero;
         F3_BLT:  cond = alu_lt;
         F3_BGE:  cond = !alu_lt;
         F3_BLTU: cond = alu_ltu;
         F3_BGEU: cond = !alu_ltu;
         default: cond = 1'b0;
      endcase
   end

   assign take = is_jal || is_jalr || (is_br && cond);

   always_comb begin
      d            = '0;
      d.store_data = id_rs2_data;
      d.rd         = id_rd;
      d.funct3     = id_funct3;
      d.mem_read   = d_mr;
      d.mem_write  = d_mw;
      d.reg_write  = d_rw && (id_rd != 5'd0);
      unique case (res_sel)
         RSEL_LT:  d.result = {31'b0, alu_lt};
         RSEL_LTU: d.result = {31'b0, alu_ltu};
         RSEL_PC4: d.result = pc4;
         default:  d.result = alu_out;
      endcase
   end

   // during the redirect pulse the input is drained as wrong-path
   assign id_ready = redir_q || !valid_q || ex_ready;
   assign accept   = id_valid && id_ready && !redir_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q       <= '0;
         valid_q <= 1'b0;
         redir_q <= 1'b0;
         rpc_q   <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
         redir_q <= 1'b0;
      end else if (accept) begin
         q       <= d;
         valid_q <= 1'b1;
         redir_q <= take;
         if (take) rpc_q <= tgt;
      end else begin
         redir_q <= 1'b0;
         if (ex_ready) valid_q <= 1'b0;
      end
   end

   assign ex_valid       = valid_q;
   assign ex_result      = q.result;
   assign ex_store_data  = q.store_data;
   assign ex_rd          = q.rd;
   assign ex_funct3      = q.funct3;
   assign ex_mem_read    = q.mem_read;
   assign ex_mem_write   = q.mem_write;
   assign ex_reg_write   = q.reg_write;
   assign redirect_valid = redir_q;
   assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: reference ALU, spec-level model, per-cycle
// compare plus directed literal checks.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid = 1'b0;
   logic        id_ready;
   logic [31:0] id_pc = '0;
   logic [31:0] id_rs1_data = '0;
   logic [31:0] id_rs2_data = '0;
   logic [31:0] id_imm = '0;
   logic [6:0]  id_opcode = '0;
   logic [2:0]  id_funct3 = '0;
   logic        id_funct7_b5 = 1'b0;
   logic [4:0]  id_rd = '0;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [2:0]  alu_op;
   logic [31:0] alu_out;
   logic        alu_zero;
   logic        alu_lt;
   logic        alu_ltu;
   logic        ex_valid;
   logic        ex_ready = 1'b1;
   logic [31:0] ex_result;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_funct3;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_reg_write;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush = 1'b0;

   int nchk = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_rs1_data(id_rs1_data),
      .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_opcode(id_opcode), .id_funct3(id_funct3),
      .id_funct7_b5(id_funct7_b5), .id_rd(id_rd),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .alu_lt(alu_lt), .alu_ltu(alu_ltu),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_result(ex_result), .ex_store_data(ex_store_data),
      .ex_rd(ex_rd), .ex_funct3(ex_funct3),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_reg_write(ex_reg_write),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush(flush)
   );

   // reference ALU driven by the stage
   always_comb begin
      alu_out = '0;
      case (alu_op)
         3'd0: alu_out = alu_in1 + alu_in2;
         3'd1: alu_out = alu_in1 - alu_in2;
         3'd2: alu_out = alu_in1 & alu_in2;
         3'd3: alu_out = alu_in1 | alu_in2;
         3'd4: alu_out = alu_in1 ^ alu_in2;
         3'd5: alu_out = alu_in1 << alu_in2[4:0];
         3'd6: alu_out = alu_in1 >> alu_in2[4:0];
         default: alu_out = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
      endcase
      alu_zero = (alu_out == 32'd0);
      alu_lt   = $signed(alu_in1) < $signed(alu_in2);
      alu_ltu  = alu_in1 < alu_in2;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f7;
      logic [4:0]  rd;
   } vec_t;

   typedef struct packed {
      logic [31:0] res;
      logic [31:0] sd;
      logic [31:0] tgt;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        mr;
      logic        mw;
      logic        rw;
      logic        known;
      logic        chk_res;
      logic        taken;
   } exp_t;

   function automatic logic [31:0] arith(input logic [2:0] f3,
      input logic sub, input logic sra,
      input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0: return sub ? a - b : a + b;
         3'd1: return a << b[4:0];
         3'd2: return {31'b0, $signed(a) < $signed(b)};
         3'd3: return {31'b0, a < b};
         3'd4: return a ^ b;
         3'd5: return sra ? $unsigned($signed(a) >>> b[4:0])
                          : a >> b[4:0];
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic exp_t model(input vec_t v);
      exp_t e;
      e = '0;
      e.rd = v.rd;
      e.f3 = v.f3;
      e.sd = v.rs2;
      e.known = 1'b1;
      e.chk_res = 1'b1;
      case (v.opc)
         7'h33: begin
            e.rw = 1'b1;
            e.res = arith(v.f3, v.f7, v.f7, v.rs1, v.rs2);
         end
         7'h13: begin
            e.rw = 1'b1;
            e.res = arith(v.f3, 1'b0, v.f7, v.rs1, v.imm);
         end
         7'h37: begin e.rw = 1'b1; e.res = v.imm; end
         7'h17: begin e.rw = 1'b1; e.res = v.pc + v.imm; end
         7'h03: begin
            e.rw = 1'b1; e.mr = 1'b1; e.res = v.rs1 + v.imm;
         end
         7'h23: begin e.mw = 1'b1; e.res = v.rs1 + v.imm; end
         7'h63: begin
            e.chk_res = 1'b0;
            e.tgt = v.pc + v.imm;
            case (v.f3)
               3'd0: e.taken = (v.rs1 == v.rs2);
               3'd1: e.taken = (v.rs1 != v.rs2);
               3'd4: e.taken = $signed(v.rs1) < $signed(v.rs2);
               3'd5: e.taken = $signed(v.rs1) >= $signed(v.rs2);
               3'd6: e.taken = v.rs1 < v.rs2;
               3'd7: e.taken = v.rs1 >= v.rs2;
               default: e.taken = 1'b0;
            endcase
         end
         7'h6f: begin
            e.rw = 1'b1; e.res = v.pc + 32'd4;
            e.taken = 1'b1; e.tgt = v.pc + v.imm;
         end
         7'h67: begin
            e.rw = 1'b1; e.res = v.pc + 32'd4;
            e.taken = 1'b1; e.tgt = (v.rs1 + v.imm) & ~32'd1;
         end
         default: begin e.known = 1'b0; e.chk_res = 1'b0; end
      endcase
      if (v.rd == 5'd0) e.rw = 1'b0;
      return e;
   endfunction

   vec_t  cur;
   exp_t  nxt;
   exp_t  m_e;
   logic  m_valid;
   logic  m_redir;
   logic [31:0] m_rpc;

   always_comb begin
      cur = {id_pc, id_rs1_data, id_rs2_data, id_imm,
             id_opcode, id_funct3, id_funct7_b5, id_rd};
      nxt = model(cur);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_redir <= 1'b0;
         m_rpc   <= '0;
         m_e     <= '0;
      end else if (flush) begin
         m_valid <= 1'b0;
         m_redir <= 1'b0;
      end else if (id_valid && !m_redir &&
                   (!m_valid || ex_ready)) begin
         m_e     <= nxt;
         m_valid <= 1'b1;
         m_redir <= nxt.taken;
         if (nxt.taken) m_rpc <= nxt.tgt;
      end else begin
         m_redir <= 1'b0;
         if (ex_ready) m_valid <= 1'b0;
      end
   end

   always @(negedge clk) begin
      chk("id_ready", {31'b0, id_ready},
          {31'b0, m_redir || !m_valid || ex_ready});
      chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
      chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_redir});
      chk("redirect_pc", redirect_pc, m_rpc);
      if (m_valid) begin
         chk("ex_reg_write", {31'b0, ex_reg_write}, {31'b0, m_e.rw});
         chk("ex_mem_read", {31'b0, ex_mem_read}, {31'b0, m_e.mr});
         chk("ex_mem_write", {31'b0, ex_mem_write}, {31'b0, m_e.mw});
         if (m_e.known) begin
            chk("ex_rd", {27'b0, ex_rd}, {27'b0, m_e.rd});
            chk("ex_funct3", {29'b0, ex_funct3}, {29'b0, m_e.f3});
         end
         if (m_e.mw) chk("ex_store_data", ex_store_data, m_e.sd);
         if (m_e.chk_res) chk("ex_result", ex_result, m_e.res);
      end
   end

   vec_t tbl [20];

   task automatic present(input vec_t v);
      id_pc        = v.pc;
      id_rs1_data  = v.rs1;
      id_rs2_data  = v.rs2;
      id_imm       = v.imm;
      id_opcode    = v.opc;
      id_funct3    = v.f3;
      id_funct7_b5 = v.f7;
      id_rd        = v.rd;
      id_valid     = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic vec_t mk(input logic [31:0] pc, rs1, rs2, imm,
      input logic [6:0] opc, input logic [2:0] f3, input logic f7,
      input logic [4:0] rd);
      return {pc, rs1, rs2, imm, opc, f3, f7, rd};
   endfunction

   initial begin
      tbl[0]  = mk(0, 5, 7, 0, 7'h33, 3'd0, 1'b0, 5'd3);
      tbl[1]  = mk(0, 3, 10, 0, 7'h33, 3'd0, 1'b1, 5'd7);
      tbl[2]  = mk(0, 32'hFFFFFFFE, 1, 0, 7'h33, 3'd2, 1'b0, 5'd8);
      tbl[3]  = mk(0, 32'hFFFFFFFE, 1, 0, 7'h33, 3'd3, 1'b0, 5'd8);
      tbl[4]  = mk(0, 32'h80000000, 0, 32'h404, 7'h13, 3'd5, 1'b1, 5'd9);
      tbl[5]  = mk(0, 100, 0, 32'hFFFFFC00, 7'h13, 3'd0, 1'b1, 5'd10);
      tbl[6]  = mk(0, 0, 0, 32'h12345000, 7'h37, 3'd0, 1'b0, 5'd11);
      tbl[7]  = mk(32'h80, 0, 0, 32'h1000, 7'h17, 3'd0, 1'b0, 5'd12);
      tbl[8]  = mk(0, 32'h1000, 0, 32'hFFFFFFFC, 7'h03, 3'd2, 1'b0, 5'd13);
      tbl[9]  = mk(0, 32'h2000, 32'hDEADBEEF, 8, 7'h23, 3'd2, 1'b0, 5'd0);
      tbl[10] = mk(32'h300, 9, 9, 32'h10, 7'h63, 3'd0, 1'b0, 5'd0);
      tbl[11] = mk(32'h300, 9, 9, 32'h10, 7'h63, 3'd1, 1'b0, 5'd0);
      tbl[12] = mk(32'h400, 0, 0, 32'hFFFFFFF0, 7'h6f, 3'd0, 1'b0, 5'd1);
      tbl[13] = mk(32'h40, 32'h1001, 0, 2, 7'h67, 3'd0, 1'b0, 5'd1);
      tbl[14] = mk(0, 1, 2, 3, 7'h7f, 3'd0, 1'b0, 5'd5);
      tbl[15] = mk(0, 5, 7, 0, 7'h33, 3'd0, 1'b0, 5'd0);
      tbl[16] = mk(0, 1, 33, 0, 7'h33, 3'd1, 1'b0, 5'd14);
      tbl[17] = mk(0, 32'h80000000, 0, 4, 7'h13, 3'd5, 1'b0, 5'd15);
      tbl[18] = mk(0, 32'hF0F0, 32'h0FF0, 0, 7'h33, 3'd7, 1'b0, 5'd16);
      tbl[19] = mk(32'h500, 32'hFFFFFFFF, 1, 8, 7'h63, 3'd5, 1'b0, 5'd0);

      // reset state
      #3;
      chk("rst ex_valid", {31'b0, ex_valid}, 32'd0);
      chk("rst redirect_valid", {31'b0, redirect_valid}, 32'd0);
      chk("rst ex_result", ex_result, 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // ADD x3 = 5 + 7
      present(tbl[0]);
      #1;
      chk("add alu_op", {29'b0, alu_op}, 32'd0);
      chk("add alu_in1", alu_in1, 32'd5);
      chk("add alu_in2", alu_in2, 32'd7);
      step();
      id_valid = 1'b0;
      chk("add ex_valid", {31'b0, ex_valid}, 32'd1);
      chk("add ex_result", ex_result, 32'd12);
      chk("add ex_rd", {27'b0, ex_rd}, 32'd3);
      chk("add ex_reg_write", {31'b0, ex_reg_write}, 32'd1);
      step();

      // BLT taken, then a wrong-path instruction is dropped
      present(mk(32'h100, 32'hFFFFFFFF, 1, 32'h20, 7'h63, 3'd4, 1'b0, 0));
      #1;
      chk("blt alu_op", {29'b0, alu_op}, 32'd1);
      step();
      chk("blt redirect_valid", {31'b0, redirect_valid}, 32'd1);
      chk("blt redirect_pc", redirect_pc, 32'h120);
      present(tbl[0]);
      #1;
      chk("wrong-path id_ready", {31'b0, id_ready}, 32'd1);
      step();
      id_valid = 1'b0;
      chk("pulse ends", {31'b0, redirect_valid}, 32'd0);
      chk("wrong-path dropped", {31'b0, ex_valid}, 32'd0);
      step();

      // BGEU taken with same operands, then not taken
      present(mk(32'h100, 32'hFFFFFFFF, 1, 32'h20, 7'h63, 3'd7, 1'b0, 0));
      step();
      id_valid = 1'b0;
      chk("bgeu redirect_valid", {31'b0, redirect_valid}, 32'd1);
      chk("bgeu redirect_pc", redirect_pc, 32'h120);
      step();
      present(mk(32'h100, 1, 2, 32'h20, 7'h63, 3'd7, 1'b0, 0));
      step();
      id_valid = 1'b0;
      chk("bgeu nt redirect", {31'b0, redirect_valid}, 32'd0);
      chk("bgeu nt ex_valid", {31'b0, ex_valid}, 32'd1);
      step();

      // JALR
      present(tbl[13]);
      step();
      id_valid = 1'b0;
      chk("jalr redirect_pc", redirect_pc, 32'h1002);
      chk("jalr ex_result", ex_result, 32'h44);
      step();

      // backpressure holds the register
      ex_ready = 1'b0;
      present(mk(0, 10, 20, 0, 7'h33, 3'd0, 1'b0, 5'd4));
      step();
      present(mk(0, 50, 8, 0, 7'h33, 3'd0, 1'b1, 5'd6));
      for (int k = 0; k < 3; k++) begin
         chk("bp id_ready", {31'b0, id_ready}, 32'd0);
         chk("bp ex_result", ex_result, 32'd30);
         chk("bp ex_rd", {27'b0, ex_rd}, 32'd4);
         step();
      end
      ex_ready = 1'b1;
      #1;
      chk("drain id_ready", {31'b0, id_ready}, 32'd1);
      step();
      id_valid = 1'b0;
      chk("drain ex_result", ex_result, 32'd42);
      chk("drain ex_rd", {27'b0, ex_rd}, 32'd6);
      step();

      // flush beats a taken branch being presented
      present(tbl[10]);
      flush = 1'b1;
      step();
      flush = 1'b0;
      id_valid = 1'b0;
      chk("flush ex_valid", {31'b0, ex_valid}, 32'd0);
      chk("flush redirect", {31'b0, redirect_valid}, 32'd0);
      step();

      // mixed stream checked by the model every cycle
      for (int i = 0; i < 300; i++) begin
         present(tbl[$urandom_range(0, 19)]);
         id_valid = ($urandom_range(0, 3) != 0);
         ex_ready = ($urandom_range(0, 3) != 0);
         flush    = ($urandom_range(0, 15) == 0);
         step();
      end
      id_valid = 1'b0;
      flush = 1'b0;
      ex_ready = 1'b1;
      step();
      step();

      // asynchronous reset mid-stream
      present(tbl[12]);
      step();
      present(tbl[0]);
      chk("pre-rst redirect_pc", redirect_pc, 32'h3F0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst ex_valid", {31'b0, ex_valid}, 32'd0);
      chk("arst redirect_valid", {31'b0, redirect_valid}, 32'd0);
      chk("arst redirect_pc", redirect_pc, 32'd0);
      chk("arst ex_result", ex_result, 32'd0);
      chk("arst ex_reg_write", {31'b0, ex_reg_write}, 32'd0);
      id_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
